// File: rtl/vga_scan_controller.sv
// 640x480@60 raster generator: 25 MHz pixel strobe, scan counters, and a one-pixel
// output register stage that aligns colour, blanking and sync on the VGA pins.
module vga_scan_controller #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_en,
    output logic       VGA_Clk,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs_d;
    logic       vs_d;
    logic       vis_d;
    logic       line_end;
    logic       frame_end;

    always_comb begin
        line_end  = (hc == H_LAST);
        frame_end = (vc == V_LAST);
        hs_d      = !((hc >= HS_START) && (hc < HS_END));
        vs_d      = !((vc >= VS_START) && (vc < VS_END));
        vis_d     = (hc < H_VIS) && (vc < V_VIS);
    end

    // Line and frame wrap share one edge, so DrawY never shows V_TOTAL.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_en <= 1'b0;
            hc       <= '0;
            vc       <= '0;
        end else begin
            pixel_en <= ~pixel_en;
            if (pixel_en) begin
                if (line_end) begin
                    hc <= '0;
                    vc <= frame_end ? '0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
            end
        end
    end

    // Pin stage holds the decode of the pixel just left, one pixel behind DrawX/DrawY.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_en && line_end && frame_end;
            if (pixel_en) begin
                VGA_HS      <= hs_d;
                VGA_VS      <= vs_d;
                VGA_BLANK_N <= vis_d;
                VGA_R       <= vis_d ? Red   : 8'h00;
                VGA_G       <= vis_d ? Green : 8'h00;
                VGA_B       <= vis_d ? Blue  : 8'h00;
            end
        end
    end

    assign DrawX      = hc;
    assign DrawY      = vc;
    assign VGA_Clk    = ~pixel_en;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: doc/vga_scan_controller.md
# vga_scan_controller

Generates the 640x480 @ 60 Hz raster for the display path. From the 50 MHz system clock it produces the 25 MHz pixel strobe and the horizontal/vertical scan counters. It presents those counters as DrawX/DrawY to the combinational colour mapper, then registers the mapper's Red/Green/Blue back in. The registered colour is driven to the VGA pins with blanking and sync pulses aligned to the same pixel.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, HS pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- Clk  in  1  50 MHz system clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Red, Green, Blue  in  8 each  colour-mapper output for the current DrawX/DrawY
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- pixel_en  out  1  high on alternate Clk cycles; every pixel-rate register advances only when high
- VGA_Clk  out  1  25 MHz pixel clock to the DAC, equal to ~pixel_en
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour
- VGA_HS, VGA_VS  out  1 each  active-low sync
- VGA_BLANK_N  out  1  low outside the visible region
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
- frame_start  out  1  one-Clk pulse at the start of each frame

## Operation
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- pixel_en is a toggle register.
- Counters:
  - When pixel_en=1, hc increments.
  - At hc=H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc=V_TOTAL-1 with hc=H_TOTAL-1, vc wraps to 0.
  - Counters hold when pixel_en=0.
- DrawX=hc and DrawY=vc, driven directly from the counter registers.
- Decode from the current hc/vc:
  - hs_d=0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_d=0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - vis_d=1 iff hc<H_VISIBLE and vc<V_VISIBLE.
- Output stage, a single pipeline register loaded when pixel_en=1:
  - VGA_HS<=hs_d, VGA_VS<=vs_d, VGA_BLANK_N<=vis_d.
  - VGA_R/G/B<=Red/Green/Blue when vis_d=1, else 0.
- frame_start is registered. It is 1 for exactly the Clk cycle after the edge on which hc=H_TOTAL-1, vc=V_TOTAL-1 and pixel_en=1, i.e. while DrawX=0 and DrawY=0 first appear.
- Colour inputs are sampled only on pixel_en=1 cycles; values on other cycles are ignored.

## Timing
- Reset (asynchronous, Reset_n=0):
  - hc=0, vc=0, pixel_en=0 (VGA_Clk=1).
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - VGA_R/G/B=0, frame_start=0.
- Release of Reset_n mid-frame restarts the scan at (0,0). No partial-frame state survives.
- After release, the first Clk edge sets pixel_en=1. The second edge advances hc to 1.
- Pin latency: VGA_R/G/B, VGA_HS, VGA_VS and VGA_BLANK_N lag DrawX/DrawY by exactly one pixel (2 Clk). All pin outputs change on the same edge.
- Line period is 800 pixels = 1600 Clk. Frame period is 420000 pixels = 840000 Clk.
- Line and frame wrap on the same edge: hc→0 and vc→0 together. No intermediate (0,V_TOTAL) value ever appears on DrawY.
- VGA_HS low for exactly 96 pixels per line. VGA_VS low for exactly 2 lines (1600 pixels) per frame, with edges aligned to hc wrap.

## Test plan
- Reset mid-frame:
  - Stimulus: hold Reset_n=0 at hc=300, vc=200, then release.
  - Required: DrawX=0, DrawY=0, VGA_BLANK_N=0, VGA_HS=1 and VGA_VS=1 immediately. DrawX=1 two Clk after release.
- Horizontal sync:
  - Stimulus: run one full line.
  - Required: VGA_HS falls one pixel after DrawX=656 and rises one pixel after DrawX=752. Low duration = 192 Clk; line period = 1600 Clk.
- Blanking and colour:
  - Stimulus: Red=8'hFF, Green=8'h80, Blue=8'h01 constant.
  - Required: VGA_R/G/B=FF/80/01 only while VGA_BLANK_N=1 (640 pixels per line, lines 0..479), otherwise 0.
- Pixel alignment:
  - Stimulus: drive Red=DrawX[7:0].
  - Required: VGA_R equals the previous pixel's DrawX[7:0]. At DrawX=1, VGA_R=0; at DrawX=100, VGA_R=99.
- Vertical sync and frame pulse:
  - Stimulus: run two frames.
  - Required:
    - VGA_VS low spans the output pixels for vc=490..491 (3200 Clk).
    - frame_start pulses once per 840000 Clk, each pulse one Clk wide, coincident with DrawX=0, DrawY=0.
- Wrap:
  - Stimulus: observe DrawX/DrawY around the end of a frame.
  - Required: (799,524) is followed directly by (0,0). DrawX never reaches 800 and DrawY never reaches 525.
